// File: rtl/cipher_pkg.sv
// Shared types and constants for the cipher datapath and its downstream serializer.
package cipher_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {IDLE, SEND} state_t;

endpackage

// File: rtl/cipher_byte_serializer_if.sv
// Byte-wide valid/ready stream leaving the serializer (toward a UART TX or FIFO).
interface cipher_byte_serializer_if;
  import cipher_pkg::*;

  logic [BYTE_W-1:0] out_byte;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  modport master (output out_byte, out_valid, out_last, input out_ready);
  modport slave  (input out_byte, out_valid, out_last, output out_ready);
endinterface

// File: rtl/cipher_edge_det.sv
// Registered rising-edge detector; a level held high produces a single pulse.
module cipher_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic d_q;

  always_ff @(posedge clk) begin
    if (!rst) d_q <= 1'b0;
    else      d_q <= d;
  end

  assign rise = d & ~d_q;
endmodule

// File: rtl/cipher_byte_serializer.sv
// Splits each N-bit ciphertext into MSB-first bytes on a valid/ready link,
// flagging frames that arrive while the previous one is still draining.
module cipher_byte_serializer
  import cipher_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      done,
  input  logic [N-1:0]              ciphertext,
  cipher_byte_serializer_if.master  tx,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      overrun,
  input  logic                      clear_err
);
  localparam int NBYTES = N / BYTE_W;
  localparam int CW     = $clog2(NBYTES + 1);

  generate
    if (N < BYTE_W || (N % BYTE_W) != 0) begin : g_bad_n
      $error("cipher_byte_serializer: N must be a positive multiple of 8");
    end
  endgenerate

  state_t         state, state_d;
  logic [N-1:0]   shreg;
  logic [CW-1:0]  cnt;
  logic           new_frame, accept, last_acc, load, shift, set_ovr;

  cipher_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (done),
    .rise (new_frame)
  );

  assign accept   = (state == SEND) & tx.out_ready;
  assign last_acc = accept & (cnt == CW'(1));
  // The last-byte cycle frees the register, so a coincident edge is a clean hand-off.
  assign set_ovr  = new_frame & (state == SEND) & ~last_acc;

  always_comb begin
    state_d = state;
    load    = 1'b0;
    shift   = 1'b0;
    case (state)
      IDLE: if (new_frame) begin
        load    = 1'b1;
        state_d = SEND;
      end
      SEND: if (accept) begin
        shift = 1'b1;
        if (cnt == CW'(1)) begin
          load    = new_frame;
          state_d = new_frame ? SEND : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_d;
      frame_done <= last_acc;
      if (load) begin
        shreg <= ciphertext;
        cnt   <= CW'(NBYTES);
      end else if (shift) begin
        shreg <= shreg << BYTE_W;
        cnt   <= cnt - CW'(1);
      end
      if (set_ovr)        overrun <= 1'b1;
      else if (clear_err) overrun <= 1'b0;
    end
  end

  // shreg drains to zero by frame end, so out_byte reads 0 whenever idle.
  assign tx.out_byte  = shreg[N-1 -: BYTE_W];
  assign tx.out_valid = (state == SEND);
  assign tx.out_last  = (state == SEND) && (cnt == CW'(1));
  assign busy         = (state == SEND);
endmodule

// File: tb/tb_cipher_byte_serializer.sv
// Directed bench for cipher_byte_serializer: N=16 main instance plus an N=24 instance.
module tb_cipher_byte_serializer;
  logic        clk = 1'b0;
  logic        rst, done, clear_err;
  logic [15:0] ct;
  logic        busy, frame_done, overrun;
  logic        done24;
  logic [23:0] ct24;
  logic        busy24, frame_done24, overrun24;

  int ncmp = 0;
  int nerr = 0;
  int nxfer = 0;
  int nfd = 0;
  logic [7:0] got [0:255];

  cipher_byte_serializer_if s16 ();
  cipher_byte_serializer_if s24 ();

  cipher_byte_serializer #(.N(16)) dut (
    .clk(clk), .rst(rst), .done(done), .ciphertext(ct), .tx(s16),
    .busy(busy), .frame_done(frame_done), .overrun(overrun), .clear_err(clear_err)
  );

  cipher_byte_serializer #(.N(24)) dut24 (
    .clk(clk), .rst(rst), .done(done24), .ciphertext(ct24), .tx(s24),
    .busy(busy24), .frame_done(frame_done24), .overrun(overrun24), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  // Transfer log for the N=16 link, sampled on the clock edge itself.
  always @(posedge clk) begin
    if (rst && s16.out_valid && s16.out_ready) begin
      got[nxfer[7:0]] <= s16.out_byte;
      nxfer           <= nxfer + 1;
    end
    if (frame_done) nfd <= nfd + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int base, fbase;

  initial begin
    rst = 1'b0; done = 1'b0; ct = '0; clear_err = 1'b0;
    done24 = 1'b0; ct24 = '0;
    s16.out_ready = 1'b0; s24.out_ready = 1'b1;

    // reset state
    step(2);
    chk("rst_valid", s16.out_valid, 0);
    chk("rst_byte",  s16.out_byte, 0);
    chk("rst_last",  s16.out_last, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_fd",    frame_done, 0);
    chk("rst_ovr",   overrun, 0);
    rst = 1'b1;
    step();

    // basic frame 665A, ready held high
    s16.out_ready = 1'b1;
    done = 1'b1; ct = 16'h665A;
    step();
    done = 1'b0;
    chk("t1_valid", s16.out_valid, 1);
    chk("t1_b0",    s16.out_byte, 8'h66);
    chk("t1_last0", s16.out_last, 0);
    step();
    chk("t1_b1",    s16.out_byte, 8'h5A);
    chk("t1_last1", s16.out_last, 1);
    step();
    chk("t1_fd",    frame_done, 1);
    chk("t1_vld0",  s16.out_valid, 0);
    chk("t1_busy0", busy, 0);
    step();
    chk("t1_fd_pulse", frame_done, 0);

    // stall: ready low for 3 cycles, byte must hold
    s16.out_ready = 1'b0;
    base = nxfer;
    done = 1'b1; ct = 16'hCCCC;
    step();
    done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t2_hold_vld", s16.out_valid, 1);
      chk("t2_hold_b",   s16.out_byte, 8'hCC);
      chk("t2_hold_lst", s16.out_last, 0);
      step();
    end
    s16.out_ready = 1'b1;
    step(4);
    chk("t2_nxfer", nxfer - base, 2);
    chk("t2_busy",  busy, 0);

    // done level held for 5 cycles: only one capture
    base = nxfer; fbase = nfd;
    done = 1'b1; ct = 16'h6666;
    step(5);
    done = 1'b0;
    step(3);
    chk("t3_nxfer", nxfer - base, 2);
    chk("t3_nfd",   nfd - fbase, 1);
    chk("t3_ovr",   overrun, 0);
    chk("t3_b0",    got[base[7:0]], 8'h66);

    // overrun while first byte stalled
    s16.out_ready = 1'b0;
    done = 1'b1; ct = 16'h665A;
    step();
    done = 1'b0;
    step();
    done = 1'b1; ct = 16'h1234;
    step();
    done = 1'b0;
    chk("t4_ovr",  overrun, 1);
    chk("t4_b0",   s16.out_byte, 8'h66);
    base = nxfer;
    s16.out_ready = 1'b1;
    step();
    chk("t4_b1",   s16.out_byte, 8'h5A);
    step();
    chk("t4_fd",   frame_done, 1);
    chk("t4_got0", got[base[7:0]], 8'h66);
    chk("t4_got1", got[base[7:0] + 8'd1], 8'h5A);
    chk("t4_ovr_sticky", overrun, 1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    chk("t4_clr",  overrun, 0);

    // back-to-back: new edge on the last-byte accept cycle
    done = 1'b1; ct = 16'h665A;
    step();
    done = 1'b0;
    chk("t5_b0", s16.out_byte, 8'h66);
    step();
    chk("t5_b1", s16.out_byte, 8'h5A);
    done = 1'b1; ct = 16'h1234;
    step();
    done = 1'b0;
    chk("t5_vld",  s16.out_valid, 1);
    chk("t5_nb0",  s16.out_byte, 8'h12);
    chk("t5_ovr",  overrun, 0);
    chk("t5_fd",   frame_done, 1);
    step();
    chk("t5_nb1",  s16.out_byte, 8'h34);
    chk("t5_nlst", s16.out_last, 1);
    step();
    chk("t5_fd2",  frame_done, 1);
    chk("t5_busy", busy, 0);
    step();

    // reset mid-frame after the first byte
    fbase = nfd;
    done = 1'b1; ct = 16'h665A;
    step();
    done = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("t6_vld",  s16.out_valid, 0);
    chk("t6_byte", s16.out_byte, 0);
    chk("t6_last", s16.out_last, 0);
    chk("t6_busy", busy, 0);
    rst = 1'b1;
    step(2);
    chk("t6_nofd", nfd - fbase, 0);
    chk("t6_fd",   frame_done, 0);
    done = 1'b1; ct = 16'hCCCC;
    step();
    done = 1'b0;
    chk("t6_rs_vld", s16.out_valid, 1);
    chk("t6_rs_b",   s16.out_byte, 8'hCC);
    step(2);
    chk("t6_rs_fd",  frame_done, 1);

    // N=24 instance
    done24 = 1'b1; ct24 = 24'h0F0F0F;
    step();
    done24 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t7_vld",  s24.out_valid, 1);
      chk("t7_byte", s24.out_byte, 8'h0F);
      chk("t7_last", s24.out_last, (i == 2) ? 1 : 0);
      step();
    end
    chk("t7_fd",   frame_done24, 1);
    chk("t7_busy", busy24, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/cipher_byte_serializer.md
Name: cipher_byte_serializer

Overview:
- Downstream stage of the XOR cipher core: consumes the N-bit ciphertext when the core signals done.
- Emits the ciphertext as a stream of 8-bit bytes, MSB byte first, over a valid/ready handshake.
- Drives a byte-wide link such as a UART TX or FIFO.
- Flags an overrun if a new ciphertext arrives before the previous frame has fully drained.

Parameters:
- N, 16, ciphertext width in bits; must be a multiple of 8 and at least 8 (elaboration-time assertion).
- NBYTES, N/8, derived localparam: bytes per frame.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset (rst=0 at a rising clk edge resets).
- done  input  1  cipher core completion flag; may be held high for several cycles.
- ciphertext  input  N  cipher core result; valid whenever done=1.
- out_byte  output  8  current byte.
- out_valid  output  1  out_byte is valid.
- out_ready  input  1  sink accepts out_byte this cycle.
- out_last  output  1  high with the final byte of a frame.
- busy  output  1  a frame is held or being sent.
- frame_done  output  1  one-cycle pulse after the last byte is accepted.
- overrun  output  1  sticky: a new done edge arrived while busy and that frame was dropped.
- clear_err  input  1  clears overrun.

Behaviour:
- Reset (rst=0 at clk edge):
  - state=IDLE; shift register, byte counter and done_q cleared to 0.
  - out_byte=0, out_valid=0, out_last=0, busy=0, frame_done=0, overrun=0.
  - Reset mid-frame discards the frame with no frame_done.
- Capture is on the rising edge of done only: new_frame = done & ~done_q, with done_q a registered copy of done. A level held high never re-captures.
- States:
  - IDLE: on new_frame, load ciphertext into the shift register, set cnt=NBYTES, go to SEND. out_valid rises on the next cycle (1-cycle latency from done first sampled high).
  - SEND:
    - out_valid=1; out_byte = shreg[N-1:N-8]; out_last = (cnt==1).
    - On out_valid & out_ready, shift shreg left by 8 and decrement cnt.
    - If the accepted byte had out_last=1: pulse frame_done on the next cycle and return to IDLE.
    - Without out_ready, out_byte and out_last hold stable (AXI-style: valid never drops before acceptance).
- busy = (state==SEND).
- Overrun:
  - new_frame in SEND, except on the last-byte-accept cycle, sets overrun=1.
  - The new ciphertext is ignored and the current frame continues unchanged.
- Simultaneous last-byte accept and new_frame: the new frame is loaded directly (back-to-back) and overrun is not set.
  - frame_done still pulses for the old frame.
  - out_valid stays high with the first byte of the new frame on the next cycle.
- clear_err=1 clears overrun. If clear_err and an overrun condition coincide, set wins (overrun=1).
- N=8: a frame is a single byte with out_last=1 immediately.
- Byte counter width: $clog2(NBYTES+1).

Decomposition:
- cipher_pkg:
  - state typedef enum logic {IDLE, SEND}.
  - localparam BYTE_W=8.
  - Shared by cipher_bonus benches.
- One natural sub-module, cipher_edge_det: registered rising-edge detector for done, reusable for start generation upstream.
- Shift register, counter and FSM stay in the top module.

Test Plan:
- Key 8'b10101010, plaintext 16'hCCF0 through cipher_bonus (ciphertext 16'h665A), out_ready=1 constant:
  - out_valid 1 cycle after done: bytes 8'h66 then 8'h5A.
  - out_last on 8'h5A only; frame_done pulses the next cycle; busy low afterwards.
- Ciphertext 16'hCCCC (key 8'hF0, plaintext 16'h3C3C), out_ready low for 3 cycles then high:
  - out_byte holds 8'hCC with valid=1 during the stall.
  - Exactly 2 transfers occur.
- done held high 5 cycles for ciphertext 16'h6666 (key 8'h33, plaintext 16'h5555): exactly one frame of 2 bytes, no overrun.
- New done edge with ciphertext 16'h1234 while the first byte of 16'h665A is stalled:
  - overrun=1; output is still 8'h66, 8'h5A.
  - clear_err clears overrun.
- Back-to-back: new done edge on the cycle 8'h5A is accepted:
  - Next cycle out_byte=8'h12, valid=1, overrun=0.
  - Frame 16'h1234 completes.
- rst=0 during SEND after the first byte: all outputs 0 next cycle, no frame_done.
  - A new done edge then restarts cleanly.
- N=24 instance, ciphertext 24'h0F0F0F: bytes 0F,0F,0F with out_last on the third.
